// File: rtl/imem_fetch_if.sv
// Signal bundle shared by the fetch controller, the instruction memory,
// the decode stage and the program loader.
interface imem_fetch_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_we;
    logic [DATA_W-1:0] imem_wdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              redirect_vld;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;
    logic              halted;

    modport master (
        output imem_addr, imem_we, imem_wdata,
        output instr_valid, instr, instr_pc,
        output ld_ack, halted,
        input  imem_rdata, instr_ready, redirect_vld, redirect_pc,
        input  halt, ld_req, ld_addr, ld_wdata
    );

    modport slave (
        input  imem_addr, imem_we, imem_wdata,
        input  instr_valid, instr, instr_pc,
        input  ld_ack, halted,
        output imem_rdata, instr_ready, redirect_vld, redirect_pc,
        output halt, ld_req, ld_addr, ld_wdata
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the instruction memory port, feeds a small
// prefetch FIFO toward decode, and hands the write port to the loader while halted.
module imem_fetch_ctrl #(
    parameter int                 ADDR_W      = 10,
    parameter int                 DATA_W      = 16,
    parameter int                 FIFO_DEPTH  = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter bit                 BOOT_HALTED = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    imem_fetch_if.master bus
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HALTED = 2'd1,
        ST_LOAD   = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam state_e RESET_STATE = BOOT_HALTED ? ST_HALTED : ST_FETCH;

    state_e                   state_q,       state_d;
    logic [ADDR_W-1:0]        fpc_q,         fpc_d;
    entry_t [FIFO_DEPTH-1:0]  fifo_q,        fifo_d;
    logic [CNT_W-1:0]         count_q,       count_d;
    logic                     instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0]        imem_addr_q,   imem_addr_d;
    logic [DATA_W-1:0]        imem_wdata_q,  imem_wdata_d;
    logic                     imem_we_q,     imem_we_d;
    logic                     ld_ack_q,      ld_ack_d;
    logic                     halted_q,      halted_d;

    logic                     fifo_full_s;
    logic                     do_flush_s;
    logic                     do_pop_s;
    logic                     do_push_s;
    logic [CNT_W-1:0]         wr_cnt_s;

    // Next-state, FIFO update and next registered-output computation.
    always_comb begin
        fifo_full_s = (count_q == CNT_W'(FIFO_DEPTH));
        do_flush_s  = bus.redirect_vld && (state_q != ST_LOAD);
        // instr_valid_q is already low in LOAD, so no pop can happen there
        do_pop_s    = instr_valid_q && bus.instr_ready && !do_flush_s;
        do_push_s   = (state_q == ST_FETCH) && !do_flush_s && (!fifo_full_s || do_pop_s);

        state_d  = state_q;
        fpc_d    = fpc_q;
        fifo_d   = fifo_q;
        count_d  = count_q;
        wr_cnt_s = count_q;

        case (state_q)
            ST_FETCH:  state_d = bus.halt ? ST_HALTED : ST_FETCH;
            ST_HALTED: begin
                if (bus.ld_req) begin
                    state_d = ST_LOAD;
                end else if (!bus.halt) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_LOAD:   state_d = ST_HALTED;
            default:   state_d = RESET_STATE;
        endcase

        if (do_flush_s) begin
            fpc_d   = bus.redirect_pc;
            count_d = '0;
        end else begin
            if (do_pop_s) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    fifo_d[i] = fifo_q[i + 1];
                end
                wr_cnt_s = count_q - CNT_W'(1);
            end else begin
                wr_cnt_s = count_q;
            end
            if (do_push_s) begin
                fifo_d[wr_cnt_s[IDX_W-1:0]].pc   = fpc_q;
                fifo_d[wr_cnt_s[IDX_W-1:0]].data = bus.imem_rdata;
                fpc_d   = fpc_q + ADDR_W'(1);
                count_d = wr_cnt_s + CNT_W'(1);
            end else begin
                count_d = wr_cnt_s;
            end
        end

        // Outputs are computed one cycle early so every port comes from a flop.
        instr_valid_d = (count_d != '0) && (state_d != ST_LOAD);
        imem_we_d     = (state_d == ST_LOAD);
        ld_ack_d      = (state_d == ST_LOAD);
        halted_d      = (state_d == ST_HALTED);
        if (state_d == ST_LOAD) begin
            imem_addr_d  = bus.ld_addr;
            imem_wdata_d = bus.ld_wdata;
        end else begin
            imem_addr_d  = fpc_d;
            imem_wdata_d = '0;
        end
    end

    // State, FIFO and output registers; reset also aborts a pending loader write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RESET_STATE;
            fpc_q         <= RESET_PC;
            fifo_q        <= '0;
            count_q       <= '0;
            instr_valid_q <= 1'b0;
            imem_addr_q   <= RESET_PC;
            imem_wdata_q  <= '0;
            imem_we_q     <= 1'b0;
            ld_ack_q      <= 1'b0;
            halted_q      <= BOOT_HALTED;
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            fifo_q        <= fifo_d;
            count_q       <= count_d;
            instr_valid_q <= instr_valid_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            imem_we_q     <= imem_we_d;
            ld_ack_q      <= ld_ack_d;
            halted_q      <= halted_d;
        end
    end

    assign bus.imem_addr   = imem_addr_q;
    assign bus.imem_we     = imem_we_q;
    assign bus.imem_wdata  = imem_wdata_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = fifo_q[0].data;
    assign bus.instr_pc    = fifo_q[0].pc;
    assign bus.ld_ack      = ld_ack_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a 1024x16 memory model and an
// in-order scoreboard of expected {pc, instr} pairs leaving the prefetch FIFO.
module tb_imem_fetch_ctrl;
    logic clk;
    logic reset;
    logic mem_init;
    int   checks;
    int   failures;

    typedef struct {
        logic [9:0]  pc;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem_model [0:1023];

    imem_fetch_if #(.ADDR_W(10), .DATA_W(16)) bus_if ();

    imem_fetch_ctrl #(
        .ADDR_W(10), .DATA_W(16), .FIFO_DEPTH(2), .RESET_PC(10'd0), .BOOT_HALTED(1'b0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_if.imem_rdata = mem_model[bus_if.imem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 1024; k++) begin
                mem_model[k] <= 16'hA000 + 16'(k);
            end
        end else if (bus_if.imem_we) begin
            mem_model[bus_if.imem_addr] <= bus_if.imem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_seq(input logic [9:0] start, input int n);
        logic [9:0] p;
        for (int i = 0; i < n; i++) begin
            p = start + 10'(i);
            sb_q.push_back('{pc: p, data: 16'hA000 + {6'd0, p}});
        end
    endtask

    // Scores any handshake that completes at the coming edge, then advances one cycle.
    task automatic tick();
        exp_t e;
        if (bus_if.instr_valid && bus_if.instr_ready && !bus_if.redirect_vld) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_underflow: observed pc=%0h expected=none", bus_if.instr_pc);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("pop_pc", 32'(bus_if.instr_pc), 32'(e.pc));
                check("pop_instr", 32'(bus_if.instr), 32'(e.data));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        mem_init = 1'b1;
        bus_if.instr_ready  = 1'b0;
        bus_if.redirect_vld = 1'b0;
        bus_if.redirect_pc  = 10'd0;
        bus_if.halt         = 1'b0;
        bus_if.ld_req       = 1'b0;
        bus_if.ld_addr      = 10'd0;
        bus_if.ld_wdata     = 16'd0;
        @(negedge clk);
        mem_init = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_valid", 32'(bus_if.instr_valid), 32'd0);
        check("rst_we", 32'(bus_if.imem_we), 32'd0);
        check("rst_ack", 32'(bus_if.ld_ack), 32'd0);
        check("rst_addr", 32'(bus_if.imem_addr), 32'd0);
        check("rst_halted", 32'(bus_if.halted), 32'd0);

        // Streaming from reset with decode always ready
        bus_if.instr_ready = 1'b1;
        sb_q.delete();
        sb_seq(10'd0, 32);
        reset = 1'b0;
        check("t1_valid_release", 32'(bus_if.instr_valid), 32'd0);
        tick();
        check("t1_first_valid", 32'(bus_if.instr_valid), 32'd1);
        check("t1_first_pc", 32'(bus_if.instr_pc), 32'd0);
        repeat (6) tick();

        // Backpressure: FIFO fills, head and fetch address hold
        bus_if.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", 32'(bus_if.instr_valid), 32'd1);
            check("t2_hold_pc", 32'(bus_if.instr_pc), 32'd6);
        end
        check("t2_fpc_stall", 32'(bus_if.imem_addr), 32'd8);
        bus_if.instr_ready = 1'b1;
        repeat (4) tick();

        // Redirect into the wrap region while the FIFO is full
        bus_if.instr_ready = 1'b0;
        tick();
        check("t3_full_addr", 32'(bus_if.imem_addr), 32'd12);
        bus_if.redirect_vld = 1'b1;
        bus_if.redirect_pc  = 10'h3FE;
        bus_if.instr_ready  = 1'b1;
        sb_q.delete();
        sb_seq(10'h3FE, 8);
        tick();
        bus_if.redirect_vld = 1'b0;
        check("t3_flushed", 32'(bus_if.instr_valid), 32'd0);
        check("t3_addr", 32'(bus_if.imem_addr), 32'h3FE);
        tick();
        check("t3_valid", 32'(bus_if.instr_valid), 32'd1);
        check("t3_pc", 32'(bus_if.instr_pc), 32'h3FE);
        repeat (4) tick();

        // Halt, one loader write, resume at the written word
        bus_if.halt        = 1'b1;
        bus_if.instr_ready = 1'b0;
        tick();
        check("t4_halted", 32'(bus_if.halted), 32'd1);
        check("t4_addr", 32'(bus_if.imem_addr), 32'd4);
        check("t4_kept_valid", 32'(bus_if.instr_valid), 32'd1);
        check("t4_kept_pc", 32'(bus_if.instr_pc), 32'd2);
        check("t4_we_idle", 32'(bus_if.imem_we), 32'd0);
        bus_if.ld_req   = 1'b1;
        bus_if.ld_addr  = 10'd5;
        bus_if.ld_wdata = 16'hBEEF;
        tick();
        check("t4_load_we", 32'(bus_if.imem_we), 32'd1);
        check("t4_load_ack", 32'(bus_if.ld_ack), 32'd1);
        check("t4_load_addr", 32'(bus_if.imem_addr), 32'd5);
        check("t4_load_wdata", 32'(bus_if.imem_wdata), 32'hBEEF);
        check("t4_load_valid", 32'(bus_if.instr_valid), 32'd0);
        bus_if.ld_req = 1'b0;
        tick();
        check("t4_post_we", 32'(bus_if.imem_we), 32'd0);
        check("t4_post_ack", 32'(bus_if.ld_ack), 32'd0);
        check("t4_post_wdata", 32'(bus_if.imem_wdata), 32'd0);
        check("t4_post_halted", 32'(bus_if.halted), 32'd1);
        check("t4_post_valid", 32'(bus_if.instr_valid), 32'd1);
        bus_if.halt         = 1'b0;
        bus_if.redirect_vld = 1'b1;
        bus_if.redirect_pc  = 10'd5;
        bus_if.instr_ready  = 1'b1;
        sb_q.delete();
        sb_q.push_back('{pc: 10'd5, data: 16'hBEEF});
        sb_seq(10'd6, 16);
        tick();
        bus_if.redirect_vld = 1'b0;
        check("t4_resume_halted", 32'(bus_if.halted), 32'd0);
        check("t4_resume_flush", 32'(bus_if.instr_valid), 32'd0);
        tick();
        check("t4_beef_valid", 32'(bus_if.instr_valid), 32'd1);
        check("t4_beef_instr", 32'(bus_if.instr), 32'hBEEF);
        repeat (3) tick();

        // Loader request while fetching is ignored until the core halts
        bus_if.ld_req   = 1'b1;
        bus_if.ld_addr  = 10'd9;
        bus_if.ld_wdata = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_we", 32'(bus_if.imem_we), 32'd0);
            check("t5_no_ack", 32'(bus_if.ld_ack), 32'd0);
        end
        bus_if.redirect_vld = 1'b1;
        bus_if.redirect_pc  = 10'h100;
        bus_if.halt         = 1'b1;
        sb_q.delete();
        tick();
        bus_if.redirect_vld = 1'b0;
        check("t5_halted", 32'(bus_if.halted), 32'd1);
        check("t5_fpc", 32'(bus_if.imem_addr), 32'h100);
        check("t5_flushed", 32'(bus_if.instr_valid), 32'd0);
        tick();
        check("t5_load_we", 32'(bus_if.imem_we), 32'd1);
        check("t5_load_ack", 32'(bus_if.ld_ack), 32'd1);
        check("t5_load_addr", 32'(bus_if.imem_addr), 32'd9);

        // Reset in the middle of the loader write
        reset = 1'b1;
        #1;
        check("t6_we_async", 32'(bus_if.imem_we), 32'd0);
        check("t6_ack_async", 32'(bus_if.ld_ack), 32'd0);
        check("t6_valid_async", 32'(bus_if.instr_valid), 32'd0);
        check("t6_addr_async", 32'(bus_if.imem_addr), 32'd0);
        check("t6_halted_async", 32'(bus_if.halted), 32'd0);
        @(posedge clk);
        #1;
        check("t6_write_aborted", 32'(mem_model[9]), 32'hA009);
        @(negedge clk);
        bus_if.ld_req       = 1'b0;
        bus_if.halt         = 1'b0;
        bus_if.instr_ready  = 1'b1;
        sb_q.delete();
        sb_seq(10'd0, 8);
        reset = 1'b0;
        tick();
        check("t6_restart_valid", 32'(bus_if.instr_valid), 32'd1);
        check("t6_restart_pc", 32'(bus_if.instr_pc), 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("t6_stream_valid", 32'(bus_if.instr_valid), 32'd0);
        check("t6_stream_addr", 32'(bus_if.imem_addr), 32'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
